demux8_rr_scheduler: RTL
========================

Name: demux8_rr_scheduler

Overview:
- Sequencing controller for the 1-to-8 demultiplexer datapath.
- Accepts a stream of words on a valid/ready input and distributes them round-robin across the enabled channels of an 8-way mask, honouring per-channel backpressure.
- Drives the demux select plus a one-hot channel valid, so the downstream 1x8 demux is steered one beat at a time.

Parameters:
- DATA_W, 8, width of the data word routed through the demux (1 reproduces the single-bit D path).
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en_mask  input  8  channel enable; bit i=1 makes channel i eligible.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_W  upstream word.
- in_ready  output  1  scheduler can accept a word this cycle.
- sel  output  3  demux select (channel index of held word).
- out_valid  output  8  one-hot valid for channel sel; all zero when nothing is held.
- out_data  output  DATA_W  held word, presented to the demux data input.
- out_ready  input  8  per-channel sink ready.
- beat_cnt  output  CNT_W  number of words delivered since reset.

Behaviour:
- State machine states:
  - IDLE: no word held.
  - HOLD: one word held in an internal register, targeted at channel sel.
- Registers: state, ptr[2:0] (round-robin start point), sel, data register, beat_cnt.
- Reset (async, any time, including mid-HOLD): state=IDLE, ptr=0, sel=0, out_valid=0, out_data=0, beat_cnt=0. Any held word is discarded. in_ready=0 while rst=1.
- Combinational outputs:
  - any_en = |en_mask.
  - xfer_out = (state==HOLD) && out_ready[sel].
  - in_ready = !rst && any_en && (state==IDLE || xfer_out).
  - out_valid = (state==HOLD) ? (8'b1 << sel) : 8'b0.
- Channel pick:
  - pick = first index k with en_mask[k]=1, searching k = base, base+1, ... wrapping 7->0.
  - base = sel+1 (mod 8) if xfer_out in that same cycle, else ptr.
- Accept (in_valid && in_ready) at edge: data register <= in_data, sel <= pick, state <= HOLD.
- Deliver (xfer_out) at edge:
  - ptr <= sel+1 (mod 8, 7 wraps to 0).
  - beat_cnt <= beat_cnt+1, wrapping at 2^CNT_W.
  - If no accept in the same cycle, state <= IDLE and out_data holds its last value.
- Simultaneous deliver + accept: new word is loaded, state stays HOLD, out_valid moves to the new sel next cycle. This gives throughput of 1 word/cycle when sinks are ready.
- Latency: word accepted at edge N appears on out_data/out_valid after edge N (one register stage).
- Backpressure: in HOLD with out_ready[sel]=0, the word, sel and out_valid hold stable indefinitely and in_ready=0.
- out_ready bits other than sel are ignored.
- en_mask is sampled only at accept. Clearing the bit of the held channel does not redirect or drop the held word.
- en_mask=0: in_ready=0 and no accept. A held word still delivers normally.
- in_valid deasserted: no state change apart from delivery.

Test Plan:
- Reset, en_mask=8'hFF, all out_ready=1, in_valid=1 with in_data=8'h10..8'h17 on consecutive cycles → sel sequence 0,1,...,7. out_valid one-hot 01,02,...,80 one cycle after each accept. in_ready stays 1. beat_cnt=8 after the 8th delivery.
- en_mask=8'b1010_0100, 6 words → sel 2,5,7,2,5,7; wrap 7->2 verified.
- en_mask=8'hFF, out_ready[3]=0 when a word targets channel 3 → sel=3, out_valid=8'h08 and out_data held stable for 5 cycles with in_ready=0. Raising out_ready[3] delivers it, and the next word goes to channel 4 in the following cycle.
- Clear en_mask bit 1 while a word for channel 1 is held → word still delivered on channel 1. Next pick skips 1.
- en_mask=0 with in_valid=1 → in_ready=0, out_valid=0 for 4 cycles. Setting en_mask=8'h40 → next word goes to channel 6.
- Assert rst mid-HOLD (word held on channel 4, out_ready=0) → out_valid=0, sel=0, beat_cnt=0 immediately. After release, the first word goes to channel 0.

Source files
------------

// File: rtl/demux8_rr_scheduler.sv
// Round-robin sequencing controller for a 1-to-8 demux: holds one word and steers it to an enabled channel.
// Latency: a word accepted at edge N is presented on out_data/out_valid after edge N (one register stage).
// Backpressure: a held word waits for out_ready[sel]; in_ready drops until it leaves (1 word/cycle when sinks are ready).
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   en_mask[7:0]         channel eligibility, sampled only when a word is accepted
//   in_valid/in_ready    upstream handshake, in_data carries the word
//   sel, out_valid[7:0]  demux select and one-hot valid for the held word
//   out_data             held word, feeds the demux data input
//   out_ready[7:0]       per-channel sink ready (only bit sel is observed)
//   beat_cnt             words delivered since reset, wraps at 2^CNT_W
`timescale 1ns/1ps
module demux8_rr_scheduler #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        en_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [2:0]        sel,
  output logic [7:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [7:0]        out_ready,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  beat_q, beat_d;

  logic       any_en;
  logic       xfer_out;
  logic       accept;
  logic [2:0] base;
  logic [2:0] pick;
  logic [2:0] idx;

  assign any_en   = |en_mask;
  assign xfer_out = (state_q == HOLD) && out_ready[sel_q];
  assign in_ready = !rst && any_en && ((state_q == IDLE) || xfer_out);
  assign accept   = in_valid && in_ready;

  // When the held word leaves this cycle its successor must not reuse the
  // same channel, so the search starts just past it rather than at ptr.
  assign base = xfer_out ? (sel_q + 3'd1) : ptr_q;

  // Walk offsets from farthest to nearest so the nearest enabled channel is
  // the last one written; pick is only consumed when any_en is set.
  always_comb begin
    pick = base;
    idx  = base;
    for (int i = 7; i >= 0; i--) begin
      idx = base + i[2:0];
      if (en_mask[idx]) begin
        pick = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    beat_d  = beat_q;
    if (xfer_out) begin
      ptr_d   = sel_q + 3'd1;
      beat_d  = beat_q + {{(CNT_W-1){1'b0}}, 1'b1};
      state_d = IDLE;
    end
    if (accept) begin
      data_d  = in_data;
      sel_d   = pick;
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      data_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = (state_q == HOLD) ? (8'b1 << sel_q) : 8'b0;
  assign out_data  = data_q;
  assign beat_cnt  = beat_q;

endmodule
